vote_tally_unit: RTL

- Parametrised successor to the single-election memory/control unit.
- Generalises candidate count, voter roll size and counter width.
- Adds:
  - an explicit election lifecycle (open → voting → close → count → result);
  - per-vote accept/reject feedback with reason codes;
  - a sequential winner scan with tie detection.
- Sits between the ballot input logic (voter ID + candidate selection) and the result display.

---
 rtl/evm_pkg.sv | 22 ++
 rtl/vote_max_scanner.sv | 70 +++++++
 rtl/vote_tally_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// Shared types and constants for the vote tally unit: FSM states, reject
// reason codes and the index-width helper used to size ports.
package evm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] REJ_NONE    = 2'd0;
  localparam logic [1:0] REJ_DUP     = 2'd1;
  localparam logic [1:0] REJ_INVALID = 2'd2;
  localparam logic [1:0] REJ_CLOSED  = 2'd3;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vote_max_scanner.sv
// Sequential argmax: takes one (index, count) pair per enabled cycle and keeps
// the running best with a tie flag; the lowest index wins among equals.
module vote_max_scanner
  import evm_pkg::*;
#(
  parameter int unsigned NUM_CANDIDATES = 4,
  parameter int unsigned COUNT_W        = 4,
  localparam int unsigned CAND_W        = idx_width(NUM_CANDIDATES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic               start_i,
  input  logic               last_i,
  input  logic [CAND_W-1:0]  idx_i,
  input  logic [COUNT_W-1:0] val_i,
  output logic [CAND_W-1:0]  best_idx_o,
  output logic [COUNT_W-1:0] best_val_o,
  output logic               tie_o,
  output logic               done_o
);

  logic [CAND_W-1:0]  best_idx_q, best_idx_d;
  logic [COUNT_W-1:0] best_val_q, best_val_d;
  logic               tie_q, tie_d;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    tie_d      = tie_q;
    if (clear_i) begin
      best_idx_d = '0;
      best_val_d = '0;
      tie_d      = 1'b0;
    end else if (en_i) begin
      if (start_i) begin
        best_idx_d = idx_i;
        best_val_d = val_i;
        tie_d      = 1'b0;
      end else if (val_i > best_val_q) begin
        best_idx_d = idx_i;
        best_val_d = val_i;
        tie_d      = 1'b0;
      end else if (val_i == best_val_q) begin
        tie_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_idx_q <= '0;
      best_val_q <= '0;
      tie_q      <= 1'b0;
    end else begin
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      tie_q      <= tie_d;
    end
  end

  assign best_idx_o = best_idx_q;
  assign best_val_o = best_val_q;
  assign tie_o      = tie_q;
  assign done_o     = en_i & last_i;

endmodule

// File: rtl/vote_tally_unit.sv
// Election controller: voter roll flags, per-candidate saturating counters,
// registered accept/reject feedback and a post-close winner scan.
module vote_tally_unit
  import evm_pkg::*;
#(
  parameter int unsigned NUM_CANDIDATES = 4,
  parameter int unsigned NUM_VOTERS     = 8,
  parameter int unsigned COUNT_W        = 4,
  localparam int unsigned CAND_W        = idx_width(NUM_CANDIDATES),
  localparam int unsigned VOTER_W       = idx_width(NUM_VOTERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               election_open,
  input  logic               election_close,
  input  logic               vote_signal,
  input  logic [VOTER_W-1:0] voter_number,
  input  logic [CAND_W-1:0]  candidate_number,
  output logic               vote_accepted,
  output logic               vote_rejected,
  output logic [1:0]         reject_code,
  output logic [COUNT_W-1:0] total_votes,
  output logic               busy,
  output logic               result_valid,
  output logic [CAND_W-1:0]  winner_candidate,
  output logic [COUNT_W-1:0] winner_votes,
  output logic               tie
);

  localparam logic [CAND_W:0]   CAND_LIMIT  = (CAND_W + 1)'(NUM_CANDIDATES);
  localparam logic [VOTER_W:0]  VOTER_LIMIT = (VOTER_W + 1)'(NUM_VOTERS);
  localparam logic [CAND_W-1:0] LAST_IDX    = CAND_W'(NUM_CANDIDATES - 1);

  state_e                   state_q, state_d;
  logic [NUM_VOTERS-1:0]    voted_q, voted_d;
  logic [COUNT_W-1:0]       cnt_q [NUM_CANDIDATES];
  logic [COUNT_W-1:0]       cnt_d [NUM_CANDIDATES];
  logic [COUNT_W-1:0]       total_q, total_d;
  logic [CAND_W-1:0]        scan_idx_q, scan_idx_d;
  logic                     acc_q, acc_d;
  logic                     rej_q, rej_d;
  logic [1:0]               code_q, code_d;

  logic                     cand_ok, voter_ok, dup;
  logic [COUNT_W-1:0]       scan_val;
  logic                     scan_clear, scan_done;

  assign cand_ok  = {1'b0, candidate_number} < CAND_LIMIT;
  assign voter_ok = {1'b0, voter_number} < VOTER_LIMIT;

  // Decoded lookups keep out-of-range indices from ever addressing the arrays.
  always_comb begin
    dup      = 1'b0;
    scan_val = '0;
    for (int v = 0; v < NUM_VOTERS; v++) begin
      if (voter_number == VOTER_W'(v) && voted_q[v]) dup = 1'b1;
    end
    for (int c = 0; c < NUM_CANDIDATES; c++) begin
      if (scan_idx_q == CAND_W'(c)) scan_val = cnt_q[c];
    end
  end

  always_comb begin
    state_d    = state_q;
    voted_d    = voted_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    scan_idx_d = scan_idx_q;
    acc_d      = 1'b0;
    rej_d      = 1'b0;
    code_d     = REJ_NONE;
    scan_clear = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (election_open) begin
          state_d    = OPEN;
          voted_d    = '0;
          total_d    = '0;
          scan_clear = 1'b1;
          for (int c = 0; c < NUM_CANDIDATES; c++) cnt_d[c] = '0;
        end
      end
      OPEN: begin
        if (vote_signal) begin
          if (!cand_ok || !voter_ok) begin
            rej_d  = 1'b1;
            code_d = REJ_INVALID;
          end else if (dup) begin
            rej_d  = 1'b1;
            code_d = REJ_DUP;
          end else begin
            // Saturated counters still record the voter and report acceptance.
            acc_d = 1'b1;
            for (int v = 0; v < NUM_VOTERS; v++) begin
              if (voter_number == VOTER_W'(v)) voted_d[v] = 1'b1;
            end
            for (int c = 0; c < NUM_CANDIDATES; c++) begin
              if (candidate_number == CAND_W'(c) && cnt_q[c] != '1)
                cnt_d[c] = cnt_q[c] + COUNT_W'(1);
            end
            if (total_q != '1) total_d = total_q + COUNT_W'(1);
          end
        end
        if (election_close) begin
          state_d    = SCAN;
          scan_idx_d = '0;
        end
      end
      SCAN: begin
        scan_idx_d = scan_idx_q + CAND_W'(1);
        if (scan_done) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (vote_signal && state_q != OPEN) begin
      rej_d  = 1'b1;
      code_d = REJ_CLOSED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      voted_q    <= '0;
      total_q    <= '0;
      scan_idx_q <= '0;
      acc_q      <= 1'b0;
      rej_q      <= 1'b0;
      code_q     <= REJ_NONE;
      // NOTE: the counter array is reset explicitly; a fresh unit must report zero votes.
      for (int c = 0; c < NUM_CANDIDATES; c++) cnt_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      voted_q    <= voted_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      scan_idx_q <= scan_idx_d;
      acc_q      <= acc_d;
      rej_q      <= rej_d;
      code_q     <= code_d;
    end
  end

  vote_max_scanner #(
    .NUM_CANDIDATES (NUM_CANDIDATES),
    .COUNT_W        (COUNT_W)
  ) u_scanner (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (scan_clear),
    .en_i       (state_q == SCAN),
    .start_i    (scan_idx_q == '0),
    .last_i     (scan_idx_q == LAST_IDX),
    .idx_i      (scan_idx_q),
    .val_i      (scan_val),
    .best_idx_o (winner_candidate),
    .best_val_o (winner_votes),
    .tie_o      (tie),
    .done_o     (scan_done)
  );

  assign vote_accepted = acc_q;
  assign vote_rejected = rej_q;
  assign reject_code   = code_q;
  assign total_votes   = total_q;
  assign busy          = (state_q == SCAN);
  assign result_valid  = (state_q == DONE);

endmodule
